// File: rtl/serial_pattern_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pattern_tx_if
//  Description : Request/stream bundle between a pattern source controller
//                and the serial_pattern_tx transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_pattern_tx_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] data;
    logic [3:0]       nbits;
    logic             hold;
    logic             dout;
    logic             dvalid;
    logic             busy;
    logic             done;
    logic             err;

    // Controller / consumer side
    modport master (
        output start, mode, data, nbits, hold,
        input  dout, dvalid, busy, done, err
    );

    // Transmitter side
    modport slave (
        input  start, mode, data, nbits, hold,
        output dout, dvalid, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pattern_tx
//  Description : Serial pattern transmitter. Sends either a captured data
//                word MSB-first or an alternating 0/1 pattern, one bit per
//                consumed cycle, with consumer stall (hold), a one-cycle done
//                pulse and a one-cycle err pulse for rejected starts.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
    parameter int WIDTH = 8
) (
    input  wire logic            clk,
    input  wire logic            reset,
    serial_pattern_tx_if.slave   bus
);

    localparam logic [1:0] c_mode_data = 2'b00;
    localparam logic [1:0] c_mode_alt1 = 2'b10;
    localparam logic [1:0] c_mode_rsvd = 2'b11;
    localparam logic [3:0] c_width     = 4'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [1:0]       r_mode;
    logic             r_dout;
    logic             r_done;
    logic             r_err;

    logic             w_illegal;
    logic [3:0]       w_eff_nbits;

    // Start legality and effective length; data mode is clipped to the word width
    always_comb begin
        w_illegal   = (bus.nbits == 4'd0) || (bus.mode == c_mode_rsvd);
        w_eff_nbits = bus.nbits;
        if ((bus.mode == c_mode_data) && (bus.nbits > c_width)) begin
            w_eff_nbits = c_width;
        end
    end

    // Transmit state machine; dout, done and err are all registered here
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_shift <= '0;
            r_mode  <= 2'b00;
            r_dout  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= SEND;
                            r_mode  <= bus.mode;
                            r_cnt   <= w_eff_nbits;
                            if (bus.mode == c_mode_data) begin
                                // First bit goes straight to dout; the rest wait in the shifter
                                r_dout  <= bus.data[WIDTH-1];
                                r_shift <= {bus.data[WIDTH-2:0], 1'b0};
                            end else begin
                                r_dout  <= (bus.mode == c_mode_alt1);
                                r_shift <= '0;
                            end
                        end
                    end
                end
                SEND: begin
                    if (!bus.hold) begin
                        if (r_cnt == 4'd1) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_dout  <= 1'b0;
                            r_cnt   <= 4'd0;
                            r_shift <= '0;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                            if (r_mode == c_mode_data) begin
                                r_dout  <= r_shift[WIDTH-1];
                                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                            end else begin
                                r_dout <= ~r_dout;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_dout  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout   = r_dout;
    assign bus.dvalid = (r_state == SEND) && !bus.hold;
    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = r_done;
    assign bus.err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_pattern_tx
//  Description : Self-checking bench for serial_pattern_tx with a bit-list
//                reference model and randomized hold / perturbation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_tx;

    localparam int W = 8;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    serial_pattern_tx_if #(.WIDTH(W)) bus ();

    serial_pattern_tx #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference bit list: what the consumer should see, from the pattern rules
    function automatic int build_expected(input logic [1:0] m, input logic [W-1:0] d,
                                          input logic [3:0] nb, output bit e[16]);
        int n;
        for (int i = 0; i < 16; i++) e[i] = 1'b0;
        if (nb == 4'd0 || m == 2'b11) return 0;
        n = (m == 2'b00 && int'(nb) > W) ? W : int'(nb);
        for (int i = 0; i < n; i++) begin
            case (m)
                2'b00:   e[i] = ((int'(d) >> (W - 1 - i)) % 2) == 1;
                2'b01:   e[i] = (i % 2) == 1;
                default: e[i] = (i % 2) == 0;
            endcase
        end
        return n;
    endfunction

    // One transaction; entered and left just after a falling edge
    task automatic run_tx(input logic [1:0] m, input logic [W-1:0] d, input logic [3:0] nb,
                          input int hold_pct, input int stall_at, input int stall_len,
                          input bit perturb);
        bit e[16];
        int n, idx, stalls, cycles, busy_cycles;
        bit h;
        n = build_expected(m, d, nb, e);
        bus.start = 1'b1; bus.mode = m; bus.data = d; bus.nbits = nb; bus.hold = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        if (n == 0) begin
            total++; if (bus.err !== 1'b1) $display("FAIL err_pulse: got %b expected 1", bus.err); else passed++;
            total++; if (bus.busy !== 1'b0) $display("FAIL err_busy: got %b expected 0", bus.busy); else passed++;
            total++; if (bus.dvalid !== 1'b0) $display("FAIL err_dvalid: got %b expected 0", bus.dvalid); else passed++;
            @(negedge clk); #1;
            total++; if (bus.err !== 1'b0) $display("FAIL err_single: got %b expected 0", bus.err); else passed++;
            total++; if (bus.busy !== 1'b0) $display("FAIL err_busy2: got %b expected 0", bus.busy); else passed++;
            return;
        end
        idx = 0; stalls = 0; cycles = 0; busy_cycles = 0;
        while (idx < n && cycles < 200) begin
            if (stall_len > 0) h = (idx == stall_at) && (stalls < stall_len);
            else h = (stalls < 20) && ($urandom_range(99) < hold_pct);
            bus.hold = h;
            if (perturb) begin
                bus.mode = 2'($urandom); bus.data = W'($urandom); bus.nbits = 4'($urandom);
                bus.start = 1'($urandom);
            end
            #1;
            total++; if (bus.busy !== 1'b1) $display("FAIL send_busy: got %b expected 1", bus.busy); else passed++;
            total++; if (bus.dvalid !== !h) $display("FAIL send_dvalid: got %b expected %b", bus.dvalid, !h); else passed++;
            total++; if (bus.dout !== e[idx]) $display("FAIL send_dout bit %0d: got %b expected %b", idx, bus.dout, e[idx]); else passed++;
            total++; if (bus.done !== 1'b0 || bus.err !== 1'b0) $display("FAIL send_flags: got done=%b err=%b expected 0 0", bus.done, bus.err); else passed++;
            busy_cycles++;
            if (h) stalls++; else idx++;
            cycles++;
            @(negedge clk);
        end
        if (idx < n) begin
            total++; $display("FAIL send_timeout: got %0d bits expected %0d", idx, n);
        end
        bus.hold = 1'b0;
        bus.start = perturb ? 1'($urandom) : 1'b0;
        #1;
        total++; if (bus.done !== 1'b1) $display("FAIL done_pulse: got %b expected 1", bus.done); else passed++;
        total++; if (bus.busy !== 1'b1 || bus.dvalid !== 1'b0 || bus.dout !== 1'b0)
            $display("FAIL done_state: got busy=%b dvalid=%b dout=%b expected 1 0 0", bus.busy, bus.dvalid, bus.dout); else passed++;
        busy_cycles++;
        total++; if (busy_cycles != n + stalls + 1) $display("FAIL busy_time: got %0d expected %0d", busy_cycles, n + stalls + 1); else passed++;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.dout !== 1'b0)
            $display("FAIL idle_after: got busy=%b done=%b err=%b dout=%b expected 0 0 0 0", bus.busy, bus.done, bus.err, bus.dout); else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.start = 1'b1; bus.hold = 1'b1; bus.mode = 2'b00; bus.data = '1; bus.nbits = 4'd8;
        repeat (3) @(negedge clk);
        #1;
        total++; if ({bus.dout, bus.dvalid, bus.busy, bus.done, bus.err} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected 00000", {bus.dout, bus.dvalid, bus.busy, bus.done, bus.err}); else passed++;
        bus.start = 1'b0; bus.hold = 1'b0; reset = 1'b1;
        @(negedge clk); #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_release_busy: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_patterns();
        run_tx(2'b00, W'(8'hA5), 4'd8, 0, 0, 0, 1'b0);
        run_tx(2'b01, '0, 4'd5, 0, 0, 0, 1'b0);
        run_tx(2'b10, '0, 4'd3, 0, 0, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_tx(2'b00, W'(8'hF0), 4'd4, 0, 2, 3, 1'b0);
    endtask

    task automatic test_reject();
        run_tx(2'b00, W'(8'h3C), 4'd0, 0, 0, 0, 1'b0);
        run_tx(2'b11, W'(8'h3C), 4'd6, 0, 0, 0, 1'b0);
    endtask

    task automatic test_truncate_and_ignore();
        run_tx(2'b00, W'(8'h6B), 4'd12, 0, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit e[16];
        int n;
        n = build_expected(2'b00, W'(8'hC3), 4'd8, e);
        bus.start = 1'b1; bus.mode = 2'b00; bus.data = W'(8'hC3); bus.nbits = 4'd8; bus.hold = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.dout !== e[i]) $display("FAIL pre_reset_dout %0d: got %b expected %b", i, bus.dout, e[i]); else passed++;
            @(negedge clk);
        end
        reset = 1'b0; bus.start = 1'b1; bus.hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            total++; if ({bus.dout, bus.dvalid, bus.busy, bus.done, bus.err} !== 5'b0)
                $display("FAIL mid_reset_outputs: got %b expected 00000", {bus.dout, bus.dvalid, bus.busy, bus.done, bus.err}); else passed++;
        end
        reset = 1'b1; bus.start = 1'b0; bus.hold = 1'b0;
        @(negedge clk); #1;
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL post_reset: got done=%b busy=%b expected 0 0", bus.done, bus.busy); else passed++;
        run_tx(2'b00, W'(8'h5A), 4'd8, 0, 0, 0, 1'b0);
        if (n != 8) begin
            total++; $display("FAIL model_len: got %0d expected 8", n);
        end
    endtask

    task automatic test_back_to_back();
        run_tx(2'b10, '0, 4'd2, 0, 0, 0, 1'b0);
        run_tx(2'b00, W'(8'h81), 4'd1, 0, 0, 0, 1'b0);
        run_tx(2'b01, '0, 4'd15, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            run_tx(2'($urandom), W'($urandom), 4'($urandom), 35, 0, 0, 1'($urandom));
        end
    endtask

    initial begin
        passed = 0; total = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.mode = 2'b00; bus.data = '0; bus.nbits = 4'd0; bus.hold = 1'b0;
        @(negedge clk);
        test_reset();
        test_patterns();
        test_stall();
        test_reject();
        test_truncate_and_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
